// File: rtl/pid_term_sched.sv
// Heading-loop PID update engine: one shared signed multiplier is sequenced
// across the P and D terms, followed by a saturating integrator and a duty clamp.
module pid_term_sched #(
    parameter logic signed [4:0] P_COEFF = 5'sh08,
    parameter logic signed [5:0] D_COEFF = 6'sh07
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [12:0]  error,
    input  logic                err_vld,
    output logic        [11:0]  drv_duty,
    output logic                duty_vld,
    output logic                busy,
    output logic                ovr,
    input  logic                ovr_clr
);

    typedef enum logic [1:0] {IDLE, MUL_P, MUL_D, SUM} state_t;

    state_t                r_state;
    state_t                w_next;
    logic signed [9:0]     r_err_p0;
    logic signed [9:0]     r_prev_err;
    logic signed [15:0]    r_integ;
    logic signed [15:0]    r_pq_p1;
    logic signed [15:0]    r_dq_p2;
    logic        [11:0]    r_duty;
    logic                  r_duty_vld;
    logic                  r_ovr;

    logic signed [9:0]     w_err_sat;
    logic signed [10:0]    w_d_diff;
    logic signed [7:0]     w_d_sat;
    logic signed [9:0]     w_mul_a;
    logic signed [5:0]     w_mul_b;
    logic signed [15:0]    w_prod;
    logic signed [16:0]    w_integ_sum;
    logic signed [11:0]    w_i_term;
    logic signed [16:0]    w_sum;
    logic                  w_accept;
    logic                  w_drop;

    function automatic logic signed [9:0] clamp_err(input logic signed [12:0] x);
        if (x > 13'sd511)
            return 10'sd511;
        else if (x < -13'sd512)
            return -10'sd512;
        else
            return x[9:0];
    endfunction

    function automatic logic signed [7:0] clamp_diff(input logic signed [10:0] x);
        if (x > 11'sd127)
            return 8'sd127;
        else if (x < -11'sd128)
            return -8'sd128;
        else
            return x[7:0];
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
        if (x > 17'sd32767)
            return 16'sh7FFF;
        else if (x < -17'sd32768)
            return 16'sh8000;
        else
            return x[15:0];
    endfunction

    function automatic logic [11:0] clamp_duty(input logic signed [16:0] x);
        if (x < 17'sd0)
            return 12'd0;
        else if (x > 17'sd4095)
            return 12'd4095;
        else
            return x[11:0];
    endfunction

    assign w_err_sat   = clamp_err(error);
    assign w_d_diff    = {r_err_p0[9], r_err_p0} - {r_prev_err[9], r_prev_err};
    assign w_d_sat     = clamp_diff(w_d_diff);
    assign w_integ_sum = {r_integ[15], r_integ} + {{7{r_err_p0[9]}}, r_err_p0};
    // Taking the upper bits of the integrator is an arithmetic shift by 4 (floor).
    assign w_i_term    = r_integ[15:4];
    assign w_sum       = {r_pq_p1[15], r_pq_p1} + {{5{w_i_term[11]}}, w_i_term}
                       + {r_dq_p2[15], r_dq_p2};
    assign w_accept    = en & err_vld & (r_state == IDLE);
    assign w_drop      = en & err_vld & (r_state != IDLE);

    always_comb begin
        w_mul_a = r_err_p0;
        w_mul_b = {P_COEFF[4], P_COEFF};
        if (r_state == MUL_D) begin
            w_mul_a = {{2{w_d_sat[7]}}, w_d_sat};
            w_mul_b = D_COEFF;
        end
    end

    assign w_prod = $signed({{6{w_mul_a[9]}}, w_mul_a}) * $signed({{10{w_mul_b[5]}}, w_mul_b});

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = MUL_P;
            MUL_P:   w_next = MUL_D;
            MUL_D:   w_next = SUM;
            SUM:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (!en)
            w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_integ    <= '0;
            r_prev_err <= '0;
            r_duty     <= '0;
            r_duty_vld <= 1'b0;
        end else begin
            r_duty_vld <= (r_state == SUM);
            case (r_state)
                // p0: capture the clamped error sample
                IDLE: begin
                    if (err_vld)
                        r_err_p0 <= w_err_sat;
                end
                // p1: proportional product and integrator update
                MUL_P: begin
                    r_pq_p1 <= w_prod;
                    r_integ <= sat16(w_integ_sum);
                end
                // p2: derivative product, remember this sample for the next difference
                MUL_D: begin
                    r_dq_p2    <= w_prod;
                    r_prev_err <= r_err_p0;
                end
                // p3: combine the three terms into the drive duty
                SUM: begin
                    r_duty <= clamp_duty(w_sum);
                end
                default: ;
            endcase
        end
    end

    // A dropped sample outranks a simultaneous clear so no overrun is ever lost.
    always_ff @(posedge clk) begin
        if (rst)
            r_ovr <= 1'b0;
        else if (w_drop)
            r_ovr <= 1'b1;
        else if (ovr_clr)
            r_ovr <= 1'b0;
    end

    assign drv_duty = r_duty;
    assign duty_vld = r_duty_vld;
    assign busy     = (r_state != IDLE);
    assign ovr      = r_ovr;

endmodule
